// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock/tick divider: per-channel 50% divided clock and one-cycle tick.
// Optional feature macro CLK_DIV_SYNC_EN adds a Sync input that phase-aligns all channels.
module clk_div_bank #(
    parameter int unsigned      CHANNELS    = 2,
    parameter int unsigned      CNT_W       = 25,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(1000000),
    parameter int unsigned      CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                En,
    input  logic                Load,
    input  logic [CH_W-1:0]     Load_ch,
    input  logic [CNT_W-1:0]    Load_div,
    output logic [CHANNELS-1:0] Clk_out,
    output logic [CHANNELS-1:0] Tick
`ifdef CLK_DIV_SYNC_EN
    ,
    input  logic                Sync
`endif
);

    logic [CHANNELS-1:0][CNT_W-1:0] r_cnt;
    logic [CHANNELS-1:0][CNT_W-1:0] r_div;
    logic [CHANNELS-1:0]            r_clk;
    logic [CHANNELS-1:0]            r_tick;
    logic [CHANNELS-1:0]            w_load_hit;
    logic [CHANNELS-1:0]            w_wrap;
    logic                           w_sync;

`ifdef CLK_DIV_SYNC_EN
    assign w_sync = Sync;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range Load_ch matches no channel, so the write is dropped.
    always_comb begin
        w_load_hit = '0;
        w_wrap     = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_load_hit[i] = Load && (Load_ch == CH_W'(i));
            w_wrap[i]     = (r_cnt[i] == r_div[i]);
        end
    end

    // Per-channel priority: sync, load, enable, wrap, count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_cnt[i] <= '0;
                r_div[i] <= DEFAULT_DIV;
            end
            r_clk  <= '0;
            r_tick <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (w_sync) begin
                    r_cnt[i]  <= '0;
                    r_clk[i]  <= 1'b0;
                    r_tick[i] <= 1'b0;
                end else if (w_load_hit[i]) begin
                    r_div[i]  <= Load_div;
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b0;
                end else if (!En) begin
                    r_tick[i] <= 1'b0;
                end else if (w_wrap[i]) begin
                    r_cnt[i]  <= '0;
                    r_clk[i]  <= ~r_clk[i];
                    r_tick[i] <= 1'b1;
                end else begin
                    r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
                    r_tick[i] <= 1'b0;
                end
            end
        end
    end

    assign Clk_out = r_clk;
    assign Tick    = r_tick;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed vector table, hand-written corner sequences,
// and randomized traffic against an arithmetic reference model. Honours CLK_DIV_SYNC_EN.
module tb_clk_div_bank;

    localparam int unsigned NCH   = 3;
    localparam int unsigned CW    = 8;
    localparam int unsigned CHW   = 2;
    localparam int          DEF   = 3;

    logic            Clk;
    logic            Reset;
    logic            En;
    logic            Load;
    logic [CHW-1:0]  Load_ch;
    logic [CW-1:0]   Load_div;
    logic [NCH-1:0]  Clk_out;
    logic [NCH-1:0]  Tick;
    logic            sync_drv;

    clk_div_bank #(
        .CHANNELS    (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (8'd3),
        .CH_W        (CHW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Load     (Load),
        .Load_ch  (Load_ch),
        .Load_div (Load_div),
        .Clk_out  (Clk_out),
        .Tick     (Tick)
`ifdef CLK_DIV_SYNC_EN
        ,
        .Sync     (sync_drv)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: enabled edges since the last load/sync/reset, and clock level at that point.
    int m_e   [NCH];
    int m_div [NCH];
    bit m_base[NCH];
    bit m_tick[NCH];
    bit m_clk [NCH];

    function automatic void model_reset();
        for (int i = 0; i < int'(NCH); i++) begin
            m_e[i] = 0; m_div[i] = DEF; m_base[i] = 1'b0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(bit en, bit ld, int ch, int dv, bit sy);
        for (int i = 0; i < int'(NCH); i++) begin
            if (sy) begin
                m_e[i] = 0; m_base[i] = 1'b0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
            end else if (ld && ch == i) begin
                m_div[i] = dv; m_e[i] = 0; m_base[i] = m_clk[i]; m_tick[i] = 1'b0;
            end else if (!en) begin
                m_tick[i] = 1'b0;
            end else begin
                m_e[i]    = m_e[i] + 1;
                m_tick[i] = (m_e[i] % (m_div[i] + 1)) == 0;
                m_clk[i]  = m_base[i] ^ (((m_e[i] / (m_div[i] + 1)) % 2) == 1);
            end
        end
    endfunction

    function automatic logic [NCH-1:0] mvec_tick();
        logic [NCH-1:0] v;
        for (int i = 0; i < int'(NCH); i++) v[i] = m_tick[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] mvec_clk();
        logic [NCH-1:0] v;
        for (int i = 0; i < int'(NCH); i++) v[i] = m_clk[i];
        return v;
    endfunction

    task automatic check(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", nm, edge_n, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", nm, edge_n, act, exp);
        end
    endtask

    // One rising edge: advance the model with the applied inputs, then compare just after the edge.
    task automatic step();
        @(posedge Clk);
        model_edge(En, Load, int'(Load_ch), int'(Load_div), sync_drv);
        edge_n++;
        #1;
        check("model_tick", Tick, mvec_tick());
        check("model_clk", Clk_out, mvec_clk());
    endtask

    typedef struct {
        logic           en;
        logic           load;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  dv;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] clk;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Edges 1..14 after reset with divisor 3; edge 13 carries an out-of-range load.
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 8'd0, 3'b000, 3'b111};
        vecs[13] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111};

        Reset = 1'b1; En = 1'b1; Load = 1'b0; Load_ch = '0; Load_div = '0; sync_drv = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_tick", Tick, 3'b000);
        check("reset_clk", Clk_out, 3'b000);
        Reset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            En = vecs[k].en; Load = vecs[k].load; Load_ch = vecs[k].ch; Load_div = vecs[k].dv;
            step();
            check("vec_tick", Tick, vecs[k].tick);
            check("vec_clk", Clk_out, vecs[k].clk);
        end
        Load = 1'b0;

        // Load ch1 with divisor 0 at edge 15: continuous tick and Clk/2 from edge 16.
        Load = 1'b1; Load_ch = 2'd1; Load_div = 8'd0;
        step();
        Load = 1'b0;
        check("div0_load_tick", Tick, 3'b000);
        check("div0_load_clk", Clk_out, 3'b111);
        step(); check("div0_e16_tick", Tick, 3'b111); check("div0_e16_clk", Clk_out, 3'b000);
        step(); check("div0_e17_tick", Tick, 3'b010); check("div0_e17_clk", Clk_out, 3'b010);
        step(); check("div0_e18_tick", Tick, 3'b010); check("div0_e18_clk", Clk_out, 3'b000);
        step(); check("div0_e19_tick", Tick, 3'b010); check("div0_e19_clk", Clk_out, 3'b010);
        step(); check("div0_e20_tick", Tick, 3'b111); check("div0_e20_clk", Clk_out, 3'b101);

        // Load ch0 with divisor 5 at edge 24, where ch0 would otherwise wrap.
        repeat (3) step();
        Load = 1'b1; Load_ch = 2'd0; Load_div = 8'd5;
        step();
        Load = 1'b0;
        check1("load_wrap_tick0", Tick[0], 1'b0);
        check1("load_wrap_clk0", Clk_out[0], 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            check1("load_wrap_quiet0", Tick[0], 1'b0);
        end
        step();
        check1("load_wrap_next_tick0", Tick[0], 1'b1);
        check1("load_wrap_next_clk0", Clk_out[0], 1'b0);

        // Disable for 7 edges (34..40) one edge after ch2 ticked; next ch2 tick moves from 36 to 43.
        repeat (3) step();
        En = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            check("en_low_tick", Tick, 3'b000);
            check("en_low_clk", Clk_out, 3'b010);
        end
        En = 1'b1;
        step(); check1("en_resume_e41", Tick[2], 1'b0);
        step(); check1("en_resume_e42", Tick[2], 1'b0);
        step(); check1("en_resume_e43", Tick[2], 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            En       = ($urandom_range(0, 9) != 0);
            Load     = ($urandom_range(0, 7) == 0);
            Load_ch  = CHW'($urandom_range(0, 3));
            Load_div = CW'($urandom_range(0, 6));
`ifdef CLK_DIV_SYNC_EN
            sync_drv = ($urandom_range(0, 63) == 0);
`endif
            step();
        end
        En = 1'b1; Load = 1'b0; sync_drv = 1'b0;

`ifdef CLK_DIV_SYNC_EN
        // Sync after ch0=2, ch1=4: clocks low next edge, wraps 3 and 5 edges later.
        Load = 1'b1; Load_ch = 2'd0; Load_div = 8'd2;
        step();
        Load_ch = 2'd1; Load_div = 8'd4;
        step();
        Load = 1'b0;
        repeat (4) step();
        sync_drv = 1'b1; Load = 1'b1; Load_ch = 2'd0; Load_div = 8'd7;
        step();
        sync_drv = 1'b0; Load = 1'b0;
        check("sync_clk", Clk_out, 3'b000);
        check("sync_tick", Tick, 3'b000);
        step(); check1("sync_s1_t0", Tick[0], 1'b0);
        step(); check1("sync_s2_t0", Tick[0], 1'b0);
        step(); check1("sync_s3_t0", Tick[0], 1'b1); check1("sync_s3_t1", Tick[1], 1'b0);
        step(); check1("sync_s4_t1", Tick[1], 1'b0);
        step(); check1("sync_s5_t1", Tick[1], 1'b1);
`endif

        // Async reset mid-period once some clock output is high.
        begin
            int guard = 0;
            while (mvec_clk() == '0 && guard < 40) begin
                step();
                guard++;
            end
            check1("pre_reset_clk_high", (mvec_clk() != '0), 1'b1);
        end
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_clk", Clk_out, 3'b000);
        check("async_reset_tick", Tick, 3'b000);
        model_reset();
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check1("post_reset_e5_clk", Clk_out[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
